// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX -> MEM pipeline register with valid/ready handshake.
//
// Define EX_MEM_SKID_EN to build the two-entry variant: an output register
// plus a skid register, with a registered ready_e. Without the macro, the
// stage is a single output register whose ready_e is combinational.
// The two builds produce the same M-port sequence for the same set of
// accepted payloads.

module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            valid_e,
    output logic            ready_e,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [RAW-1:0]  RdE,
    input  logic            PCJalSrcE,

    input  logic            flush,

    output logic            valid_m,
    input  logic            ready_m,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [RAW-1:0]  RdM,
    output logic            PCJalSrcM
);

    // Payload is carried as one packed word so both registers share a layout:
    // {ALUResult, WriteData, PCPlus4, Rd, PCJalSrc}
    localparam int PW      = 3 * XLEN + RAW + 1;
    localparam int JAL_LSB = 0;
    localparam int RD_LSB  = 1;
    localparam int PC4_LSB = RAW + 1;
    localparam int WD_LSB  = PC4_LSB + XLEN;
    localparam int ALU_LSB = WD_LSB + XLEN;

    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] r_out_payload;
    logic          r_valid_m;
    logic          w_drain;
    logic          w_accept;

    assign w_in_payload = {ALUResultE, WriteDataE, PCPlus4E, RdE, PCJalSrcE};

    // Output register is free this edge when empty or being consumed.
    assign w_drain = !r_valid_m || ready_m;

    assign valid_m    = r_valid_m;
    assign ALUResultM = r_out_payload[ALU_LSB +: XLEN];
    assign WriteDataM = r_out_payload[WD_LSB  +: XLEN];
    assign PCPlus4M   = r_out_payload[PC4_LSB +: XLEN];
    assign RdM        = r_out_payload[RD_LSB  +: RAW];
    assign PCJalSrcM  = r_out_payload[JAL_LSB];

`ifdef EX_MEM_SKID_EN

    logic          r_skid_valid;
    logic [PW-1:0] r_skid_payload;
    logic          r_ready_e;

    // ready_e is a flop that always mirrors NOT(skid valid), so the upstream
    // never sees a combinational path from ready_m.
    assign ready_e  = r_ready_e;
    assign w_accept = valid_e && r_ready_e && !flush;

    // Output/skid register update: skid refills the output first, new
    // payloads land in the output when it drains, otherwise in the skid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_m      <= 1'b0;
            r_out_payload  <= '0;
            r_skid_valid   <= 1'b0;
            r_skid_payload <= '0;
            r_ready_e      <= 1'b1;
        end else if (flush) begin
            r_valid_m    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready_e    <= 1'b1;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                // ready_e was low, so nothing new can arrive this edge.
                r_out_payload <= r_skid_payload;
                r_valid_m     <= 1'b1;
                r_skid_valid  <= 1'b0;
                r_ready_e     <= 1'b1;
            end else if (w_accept) begin
                r_out_payload <= w_in_payload;
                r_valid_m     <= 1'b1;
            end else begin
                r_valid_m <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_payload <= w_in_payload;
            r_skid_valid   <= 1'b1;
            r_ready_e      <= 1'b0;
        end
    end

`else

    // Single-entry build: accept whenever the output register frees up.
    assign ready_e  = w_drain;
    assign w_accept = valid_e && w_drain && !flush;

    // Output register update: load on accept, empty on drain, clear on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_m     <= 1'b0;
            r_out_payload <= '0;
        end else if (flush) begin
            r_valid_m <= 1'b0;
        end else if (w_accept) begin
            r_out_payload <= w_in_payload;
            r_valid_m     <= 1'b1;
        end else if (ready_m) begin
            r_valid_m <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk;
    logic        reset;
    logic        valid_e, ready_e, flush, valid_m, ready_m;
    logic [31:0] alu_e, wd_e, pc4_e, alu_m, wd_m, pc4_m;
    logic [4:0]  rd_e, rd_m;
    logic        jal_e, jal_m;

    logic        valid_e64, ready_e64, flush64, valid_m64, ready_m64;
    logic [63:0] alu_e64, wd_e64, pc4_e64, alu_m64, wd_m64, pc4_m64;
    logic [5:0]  rd_e64, rd_m64;
    logic        jal_e64, jal_m64;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_stage u_dut (
        .clk(clk), .reset(reset),
        .valid_e(valid_e), .ready_e(ready_e),
        .ALUResultE(alu_e), .WriteDataE(wd_e), .PCPlus4E(pc4_e),
        .RdE(rd_e), .PCJalSrcE(jal_e),
        .flush(flush),
        .valid_m(valid_m), .ready_m(ready_m),
        .ALUResultM(alu_m), .WriteDataM(wd_m), .PCPlus4M(pc4_m),
        .RdM(rd_m), .PCJalSrcM(jal_m)
    );

    ex_mem_stage #(.XLEN(64), .RAW(6)) u_dut64 (
        .clk(clk), .reset(reset),
        .valid_e(valid_e64), .ready_e(ready_e64),
        .ALUResultE(alu_e64), .WriteDataE(wd_e64), .PCPlus4E(pc4_e64),
        .RdE(rd_e64), .PCJalSrcE(jal_e64),
        .flush(flush64),
        .valid_m(valid_m64), .ready_m(ready_m64),
        .ALUResultM(alu_m64), .WriteDataM(wd_m64), .PCPlus4M(pc4_m64),
        .RdM(rd_m64), .PCJalSrcM(jal_m64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid_m: got %0b exp 0", valid_m); end
        n_checks++; if (alu_m !== 32'h0) begin n_fail++; $display("FAIL reset_alu_m: got %h exp 0", alu_m); end
        n_checks++; if (rd_m !== 5'h0) begin n_fail++; $display("FAIL reset_rd_m: got %h exp 0", rd_m); end
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL reset_ready_e: got %0b exp 1", ready_e); end
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %0b exp 0", valid_m); end
    endtask

    task automatic test_streaming;
        logic [31:0] vals [4];
        vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30; vals[3] = 32'h40;
        ready_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_e = 1'b1;
            alu_e   = vals[i];
            #1;
            n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL stream_ready_e%0d: got %0b exp 1", i, ready_e); end
            tick();
            n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %0b exp 1", i, valid_m); end
            n_checks++; if (alu_m !== vals[i]) begin n_fail++; $display("FAIL stream_alu%0d: got %h exp %h", i, alu_m, vals[i]); end
        end
        valid_e = 1'b0;
        tick();
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %0b exp 0", valid_m); end
        n_checks++; if (alu_m !== 32'h40) begin n_fail++; $display("FAIL stream_retain_alu: got %h exp 40", alu_m); end
    endtask

    task automatic test_fields;
        ready_m = 1'b1;
        valid_e = 1'b1;
        alu_e = 32'hA5A5_5A5A; wd_e = 32'h1234_5678; pc4_e = 32'h0000_1004;
        rd_e = 5'h1F; jal_e = 1'b1;
        tick();
        valid_e = 1'b0;
        n_checks++; if (alu_m !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL fields_alu: got %h exp a5a55a5a", alu_m); end
        n_checks++; if (wd_m !== 32'h1234_5678) begin n_fail++; $display("FAIL fields_wd: got %h exp 12345678", wd_m); end
        n_checks++; if (pc4_m !== 32'h0000_1004) begin n_fail++; $display("FAIL fields_pc4: got %h exp 00001004", pc4_m); end
        n_checks++; if (rd_m !== 5'h1F) begin n_fail++; $display("FAIL fields_rd: got %h exp 1f", rd_m); end
        n_checks++; if (jal_m !== 1'b1) begin n_fail++; $display("FAIL fields_jal: got %0b exp 1", jal_m); end
        jal_e = 1'b0; rd_e = 5'h0; wd_e = 32'h0; pc4_e = 32'h0;
        tick();
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL fields_drain: got %0b exp 0", valid_m); end
    endtask

    task automatic test_backpressure;
        // A accepted with the output empty
        ready_m = 1'b1; valid_e = 1'b1; alu_e = 32'h11;
        tick();
        n_checks++; if (alu_m !== 32'h11 || valid_m !== 1'b1) begin n_fail++; $display("FAIL bp_a_loaded: got v=%0b %h exp v=1 11", valid_m, alu_m); end
        // B offered while MEM stalls
        ready_m = 1'b0; alu_e = 32'h22;
`ifdef EX_MEM_SKID_EN
        tick();
        valid_e = 1'b0;
        n_checks++; if (ready_e !== 1'b0) begin n_fail++; $display("FAIL bp_ready_e_low: got %0b exp 0", ready_e); end
        n_checks++; if (alu_m !== 32'h11) begin n_fail++; $display("FAIL bp_hold1: got %h exp 11", alu_m); end
        tick();
        n_checks++; if (alu_m !== 32'h11 || valid_m !== 1'b1) begin n_fail++; $display("FAIL bp_hold2: got v=%0b %h exp v=1 11", valid_m, alu_m); end
        ready_m = 1'b1;
        tick();
        n_checks++; if (alu_m !== 32'h22 || valid_m !== 1'b1) begin n_fail++; $display("FAIL bp_b_out: got v=%0b %h exp v=1 22", valid_m, alu_m); end
        n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL bp_ready_e_back: got %0b exp 1", ready_e); end
`else
        #1;
        n_checks++; if (ready_e !== 1'b0) begin n_fail++; $display("FAIL bp_ready_e_low: got %0b exp 0", ready_e); end
        tick();
        n_checks++; if (alu_m !== 32'h11) begin n_fail++; $display("FAIL bp_hold1: got %h exp 11", alu_m); end
        tick();
        n_checks++; if (alu_m !== 32'h11 || valid_m !== 1'b1) begin n_fail++; $display("FAIL bp_hold2: got v=%0b %h exp v=1 11", valid_m, alu_m); end
        ready_m = 1'b1;
        #1;
        n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL bp_ready_e_back: got %0b exp 1", ready_e); end
        tick();
        valid_e = 1'b0;
        n_checks++; if (alu_m !== 32'h22 || valid_m !== 1'b1) begin n_fail++; $display("FAIL bp_b_out: got v=%0b %h exp v=1 22", valid_m, alu_m); end
`endif
        valid_e = 1'b0;
        tick();
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b exp 0", valid_m); end
    endtask

    task automatic test_flush;
        int seen7;
        seen7 = 0;
        ready_m = 1'b1; valid_e = 1'b1; alu_e = 32'h31; rd_e = 5'd1;
        tick();
        ready_m = 1'b0; alu_e = 32'h32; rd_e = 5'd2;
        tick();
        // output (and skid, when present) now hold payloads
        flush = 1'b1; valid_e = 1'b1; rd_e = 5'd7; alu_e = 32'h77;
        tick();
        flush = 1'b0; valid_e = 1'b0; rd_e = 5'd0;
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL flush_valid_m: got %0b exp 0", valid_m); end
        n_checks++; if (ready_e !== 1'b1) begin n_fail++; $display("FAIL flush_ready_e: got %0b exp 1", ready_e); end
        ready_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid_m === 1'b1) seen7++;
        end
        n_checks++; if (seen7 !== 0) begin n_fail++; $display("FAIL flush_no_revival: got %0d valid cycles exp 0", seen7); end
    endtask

    task automatic test_async_reset;
        ready_m = 1'b1; valid_e = 1'b1; alu_e = 32'hDEAD_BEEF; rd_e = 5'd9;
        wd_e = 32'h5555_AAAA; pc4_e = 32'h8; jal_e = 1'b1;
        tick();
        ready_m = 1'b0; valid_e = 1'b0; jal_e = 1'b0; wd_e = 32'h0; pc4_e = 32'h0; rd_e = 5'd0;
        n_checks++; if (alu_m !== 32'hDEAD_BEEF || valid_m !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got v=%0b %h exp v=1 deadbeef", valid_m, alu_m); end
        #3 reset = 1'b1;
        #1;
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b exp 0", valid_m); end
        n_checks++; if (alu_m !== 32'h0 || wd_m !== 32'h0 || pc4_m !== 32'h0 || rd_m !== 5'h0 || jal_m !== 1'b0) begin
            n_fail++; $display("FAIL areset_payload: got %h %h %h %h %0b exp all 0", alu_m, wd_m, pc4_m, rd_m, jal_m);
        end
        #1 reset = 1'b0;
        valid_e = 1'b1; alu_e = 32'h55; ready_m = 1'b1;
        tick();
        valid_e = 1'b0;
        n_checks++; if (valid_m !== 1'b1 || alu_m !== 32'h55) begin n_fail++; $display("FAIL areset_first: got v=%0b %h exp v=1 55", valid_m, alu_m); end
        tick();
    endtask

    task automatic test_param64;
        ready_m64 = 1'b1; valid_e64 = 1'b1;
        alu_e64 = 64'hFFFF_0000_1234_5678; rd_e64 = 6'd63;
        wd_e64 = 64'h8000_0000_0000_0001; pc4_e64 = 64'hFFFF_FFFF_FFFF_FFFC; jal_e64 = 1'b1;
        tick();
        valid_e64 = 1'b0;
        n_checks++; if (valid_m64 !== 1'b1) begin n_fail++; $display("FAIL p64_valid: got %0b exp 1", valid_m64); end
        n_checks++; if (alu_m64 !== 64'hFFFF_0000_1234_5678) begin n_fail++; $display("FAIL p64_alu: got %h exp ffff000012345678", alu_m64); end
        n_checks++; if (rd_m64 !== 6'd63) begin n_fail++; $display("FAIL p64_rd: got %0d exp 63", rd_m64); end
        n_checks++; if (wd_m64 !== 64'h8000_0000_0000_0001 || pc4_m64 !== 64'hFFFF_FFFF_FFFF_FFFC || jal_m64 !== 1'b1) begin
            n_fail++; $display("FAIL p64_other: got %h %h %0b", wd_m64, pc4_m64, jal_m64);
        end
    endtask

    initial begin
        reset = 1'b1;
        valid_e = 1'b0; ready_m = 1'b0; flush = 1'b0;
        alu_e = '0; wd_e = '0; pc4_e = '0; rd_e = '0; jal_e = 1'b0;
        valid_e64 = 1'b0; ready_m64 = 1'b0; flush64 = 1'b0;
        alu_e64 = '0; wd_e64 = '0; pc4_e64 = '0; rd_e64 = '0; jal_e64 = 1'b0;

        test_reset();
        test_streaming();
        test_fields();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_param64();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
